// File: rtl/scb_banked_memory_if.sv
// SCB slave bus bundle for scb_banked_memory.
// Signal names follow the Minx16 SCB pin names.
interface scb_banked_memory_if #(
    parameter int A = 11,
    parameter int D = 16
);
    localparam int B = D / 8;

    logic [A-1:0] scb_Addr_i;
    logic [D-1:0] scb_Data_i;
    logic [D-1:0] scb_Data_o;
    logic [B-1:0] scb_stb_i;
    logic         scb_ce_i;
    logic         scb_rd_i;
    logic         scb_wr_i;
    logic         scb_rdy_o;
    logic         scb_ack_o;

    modport master (
        output scb_Addr_i, scb_Data_i, scb_stb_i,
        output scb_ce_i, scb_rd_i, scb_wr_i,
        input  scb_Data_o, scb_rdy_o, scb_ack_o
    );

    modport slave (
        input  scb_Addr_i, scb_Data_i, scb_stb_i,
        input  scb_ce_i, scb_rd_i, scb_wr_i,
        output scb_Data_o, scb_rdy_o, scb_ack_o
    );
endinterface

// File: rtl/scb_banked_memory.sv
// Banked SCB scratchpad with zero-fill after reset.
// Define SCB_OUTREG_EN to add an output register (latency 2).
module scb_banked_memory #(
    parameter int A     = 11,
    parameter int D     = 16,
    parameter int NBANK = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    scb_banked_memory_if.slave scb
);
    localparam int B   = D / 8;
    localparam int LB  = $clog2(B);
    localparam int NBB = $clog2(NBANK);
    localparam int BSW = (NBB > 0) ? NBB : 1;
    localparam int IW  = A - NBB - LB;
    localparam int W   = 1 << IW;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic             rdy;
    logic             accept;
    logic             wr_acc;
    logic             rd_acc;
    logic             clearing;
    logic [IW-1:0]    idx;
    logic [BSW-1:0]   bank;
    logic [BSW-1:0]   bank_q;
    logic             ack_q;
    logic             rvalid_q;
    logic [D-1:0]     mux;

    logic [NBANK-1:0][D-1:0] rdata;

    assign idx = scb.scb_Addr_i[A-1-NBB -: IW];

    if (NBB > 0) begin : g_bank
        assign bank = scb.scb_Addr_i[A-1 -: NBB];
    end else begin : g_nobank
        assign bank = '0;
    end

    if (LB > 0) begin : g_lo
        logic unused_lo;
        assign unused_lo = ^scb.scb_Addr_i[LB-1:0];
    end

    assign clearing = (state_q == CLEAR);
    assign accept   = scb.scb_ce_i & (scb.scb_rd_i | scb.scb_wr_i) & rdy;
    assign wr_acc   = accept & scb.scb_wr_i;
    assign rd_acc   = accept & ~scb.scb_wr_i;

    // FSM and clear-counter state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every index once, then serve requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy     = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = IDLE;
            end
            IDLE: rdy = 1'b1;
            default: state_d = CLEAR;
        endcase
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bk
        for (genvar l = 0; l < B; l++) begin : g_ln
            logic [7:0]    mem [W];
            logic [7:0]    q;
            logic          sel;
            logic          we;
            logic          re;
            logic [IW-1:0] a;
            logic [7:0]    wd;

            assign sel = (bank == BSW'(b));
            assign we  = clearing | (wr_acc & sel & scb.scb_stb_i[l]);
            assign re  = rd_acc & sel;
            assign a   = clearing ? cnt_q : idx;
            assign wd  = clearing ? 8'h00 : scb.scb_Data_i[8*l +: 8];

            // Byte-lane array: synchronous write and read
            always_ff @(posedge clk_i) begin
                if (we) mem[a] <= wd;
                if (re) q <= mem[a];
            end

            assign rdata[b][8*l +: 8] = q;
        end
    end

    // Request tracking: ack, read-valid and registered bank select
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            bank_q   <= '0;
        end else begin
            ack_q    <= accept;
            rvalid_q <= rd_acc;
            if (rd_acc) bank_q <= bank;
        end
    end

    assign mux = rdata[bank_q];
    assign scb.scb_rdy_o = rdy;

`ifdef SCB_OUTREG_EN
    logic [D-1:0] out_q;
    logic         ack2_q;

    // Extra output stage after the bank mux
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_q  <= '0;
            ack2_q <= 1'b0;
        end else begin
            ack2_q <= ack_q;
            if (rvalid_q) out_q <= mux;
        end
    end

    assign scb.scb_Data_o = out_q;
    assign scb.scb_ack_o  = ack2_q;
`else
    logic [D-1:0] hold_q;

    // Keep the last read word once the array output moves on
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_q <= '0;
        end else if (rvalid_q) begin
            hold_q <= mux;
        end
    end

    assign scb.scb_Data_o = rvalid_q ? mux : hold_q;
    assign scb.scb_ack_o  = ack_q;
`endif
endmodule

// File: tb/tb_scb_banked_memory.sv
// Randomised self-checking bench for scb_banked_memory.
// Byte-addressed memory model plus latency queue.
module tb_scb_banked_memory;
    localparam int A     = 11;
    localparam int D     = 16;
    localparam int NBANK = 2;
    localparam int B     = D / 8;
    localparam int W     = (1 << A) / (NBANK * B);
`ifdef SCB_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        bit           acc;
        bit           rd;
        logic [D-1:0] val;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scb_banked_memory_if #(.A(A), .D(D)) bus ();

    scb_banked_memory #(.A(A), .D(D), .NBANK(NBANK)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .scb   (bus)
    );

    logic [7:0]   mm [1 << A];
    ent_t         pq [$];
    int           since;
    logic [D-1:0] exp_data;
    int           n_chk = 0;
    int           n_err = 0;
    logic [D-1:0] obs_d [8];
    logic         obs_a [8];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] mread(int adr);
        logic [D-1:0] v;
        int base;
        base = adr & ~(B - 1);
        for (int k = 0; k < B; k++) v[8*k +: 8] = mm[base + k];
        return v;
    endfunction

    task automatic mwrite(int adr, logic [D-1:0] d, logic [B-1:0] s);
        int base;
        base = adr & ~(B - 1);
        for (int k = 0; k < B; k++)
            if (s[k]) mm[base + k] = d[8*k +: 8];
    endtask

    task automatic model_reset();
        since = 0;
        pq.delete();
        exp_data = '0;
        for (int i = 0; i < (1 << A); i++) mm[i] = 8'h00;
    endtask

    task automatic drive(bit ce, bit rd, bit wr, int adr,
                         logic [D-1:0] d, logic [B-1:0] s);
        bus.scb_ce_i   = ce;
        bus.scb_rd_i   = rd;
        bus.scb_wr_i   = wr;
        bus.scb_Addr_i = adr[A-1:0];
        bus.scb_Data_i = d;
        bus.scb_stb_i  = s;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, '0);
    endtask

    // One clock: predict this edge, then compare all outputs
    task automatic tick();
        ent_t e;
        bit   rdy_m;
        rdy_m = rst_n && (since >= W);
        e.acc = rdy_m && bus.scb_ce_i && (bus.scb_rd_i || bus.scb_wr_i);
        e.rd  = e.acc && !bus.scb_wr_i;
        e.val = e.rd ? mread(int'(bus.scb_Addr_i)) : '0;
        if (e.acc && bus.scb_wr_i)
            mwrite(int'(bus.scb_Addr_i), bus.scb_Data_i, bus.scb_stb_i);
        @(posedge clk);
        #1;
        if (rst_n) begin
            since++;
            pq.push_back(e);
        end else begin
            since = 0;
            pq.delete();
            exp_data = '0;
        end
        if (pq.size() == L) begin
            e = pq.pop_front();
            if (e.rd) exp_data = e.val;
            chk("ack", 32'(bus.scb_ack_o), 32'(e.acc));
        end else begin
            chk("ack", 32'(bus.scb_ack_o), 32'(0));
        end
        chk("data", 32'(bus.scb_Data_o), 32'(exp_data));
        chk("rdy", 32'(bus.scb_rdy_o), 32'(rst_n && since >= W));
    endtask

    task automatic clear_wait();
        int n;
        n = 0;
        while (!bus.scb_rdy_o && n < 2000) begin
            n++;
            tick();
        end
        idle();
        chk("clear_cycles", 32'(n), 32'(512));
    endtask

    task automatic op_write(int adr, logic [D-1:0] d, logic [B-1:0] s);
        drive(1, 0, 1, adr, d, s);
        tick();
        idle();
        repeat (L - 1) tick();
        chk("wr_ack", 32'(bus.scb_ack_o), 32'(1));
    endtask

    task automatic op_read(string nm, int adr, logic [D-1:0] exp);
        drive(1, 1, 0, adr, '0, '0);
        tick();
        idle();
        repeat (L - 1) tick();
        chk({nm, "_ack"}, 32'(bus.scb_ack_o), 32'(1));
        chk(nm, 32'(bus.scb_Data_o), 32'(exp));
    endtask

    initial begin
        int nack;
        idle();
        model_reset();
        #12;
        chk("rst_rdy", 32'(bus.scb_rdy_o), 32'(0));
        chk("rst_ack", 32'(bus.scb_ack_o), 32'(0));
        chk("rst_data", 32'(bus.scb_Data_o), 32'(0));

        // Write presented throughout CLEAR must be ignored
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 1, 'h050, 16'hFFFF, 2'b11);
        clear_wait();

        op_read("clr_000", 'h000, 16'h0000);
        op_read("clr_3fe", 'h3FE, 16'h0000);
        op_read("clr_400", 'h400, 16'h0000);
        op_read("clr_7fe", 'h7FE, 16'h0000);
        op_read("clr_050", 'h050, 16'h0000);

        op_write('h010, 16'hA55A, 2'b01);
        op_write('h010, 16'h1234, 2'b10);
        op_read("lanes", 'h010, 16'h125A);

        op_write('h020, 16'hBEEF, 2'b11);
        op_write('h420, 16'hCAFE, 2'b11);
        drive(1, 1, 0, 'h020, '0, '0);
        tick();
        obs_d[0] = bus.scb_Data_o;
        obs_a[0] = bus.scb_ack_o;
        drive(1, 1, 0, 'h420, '0, '0);
        for (int i = 1; i < 4; i++) begin
            tick();
            obs_d[i] = bus.scb_Data_o;
            obs_a[i] = bus.scb_ack_o;
            drive(0, 0, 0, 'h010, '0, '0);
        end
        chk("bank0", 32'(obs_d[L-1]), 32'('hBEEF));
        chk("bank0_ack", 32'(obs_a[L-1]), 32'(1));
        chk("bank1", 32'(obs_d[L]), 32'('hCAFE));
        chk("bank1_ack", 32'(obs_a[L]), 32'(1));
        chk("bank_hold", 32'(obs_d[L+1]), 32'('hCAFE));

        nack = 0;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(1, 1, 0, 'h000, '0, '0);
                1: drive(1, 1, 0, 'h010, '0, '0);
                2: drive(1, 1, 0, 'h020, '0, '0);
                3: drive(1, 1, 0, 'h420, '0, '0);
                default: idle();
            endcase
            tick();
            nack += int'(bus.scb_ack_o);
        end
        chk("burst_acks", 32'(nack), 32'(4));
        chk("burst_last", 32'(bus.scb_Data_o), 32'('hCAFE));

        drive(1, 1, 1, 'h030, 16'h7777, 2'b11);
        tick();
        idle();
        repeat (L - 1) tick();
        chk("rdwr_ack", 32'(bus.scb_ack_o), 32'(1));
        chk("rdwr_data", 32'(bus.scb_Data_o), 32'('hCAFE));
        op_read("rdwr_rb", 'h030, 16'h7777);

        for (int i = 0; i < 600; i++) begin
            int adr;
            if ($urandom_range(0, 1) == 0)
                adr = int'($urandom_range(0, (1 << A) - 1));
            else
                adr = ($urandom_range(0, 1) << (A - 1)) |
                      ($urandom_range(0, 7) << 1) | $urandom_range(0, 1);
            drive(($urandom % 5) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, adr,
                  D'($urandom), B'($urandom));
            tick();
        end
        idle();
        repeat (3) tick();

        op_write('h060, 16'h1111, 2'b11);
        drive(1, 1, 0, 'h060, '0, '0);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_ack", 32'(bus.scb_ack_o), 32'(0));
        chk("mid_data", 32'(bus.scb_Data_o), 32'(0));
        chk("mid_rdy", 32'(bus.scb_rdy_o), 32'(0));
        model_reset();
        idle();
        repeat (2) tick();
        rst_n = 1'b1;
        clear_wait();
        op_read("reclr_060", 'h060, 16'h0000);
        op_read("reclr_010", 'h010, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
